// File: rtl/rst_seq_pkg.sv
// ----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset sequencer: the sequencer state encoding,
// the default timing constants and a helper that sizes the sequencing
// counter from the timing parameters.
// ----------------------------------------------------------------------------
package rst_seq_pkg;

   // Sequencer states; the numeric values are visible on seq_state for debug.
   typedef enum logic [2:0] {
      ST_HOLD        = 3'd0,
      ST_WAIT_STABLE = 3'd1,
      ST_REL_PERIPH  = 3'd2,
      ST_WAIT_GAP    = 3'd3,
      ST_RUN         = 3'd4
   } state_e;

   localparam int DEF_STARTUP_CYCLES = 1024;
   localparam int DEF_GAP_CYCLES     = 16;
   localparam int DEF_HOLD_MIN       = 8;

   // Largest of three values.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

   // Counter width: one bit of headroom above the largest terminal count.
   function automatic int cnt_width(input int a, input int b, input int c);
      return $clog2(max3(a, b, c)) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous bit.
//   clk  : destination clock
//   rst  : synchronous active-high reset, loads RST_VAL into both flops
//   i_d  : asynchronous input
//   o_q  : synchronised output (two clk edges of latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Metastability-settling shift of the asynchronous input.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// ----------------------------------------------------------------------------
// reset_sequencer
// Power-on / request-driven reset sequencer. Holds peripheral and core resets
// for a minimum time, waits for clock stabilisation, releases the peripheral
// reset, then the core reset a fixed gap later. Any request restarts the
// whole sequence from HOLD.
//   clk           : 160 MHz system clock
//   rst           : synchronous active-high reset
//   ext_rst_req_n : asynchronous board reset button, active-low
//   sw_rst_req    : single-cycle synchronous software reset request
//   periph_rst    : active-high reset to bus/peripheral logic (registered)
//   core_rst      : active-high reset to the core (registered)
//   seq_done      : high while the sequencer is in RUN
//   seq_state     : current state encoding, for debug
// ----------------------------------------------------------------------------
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int HOLD_MIN       = DEF_HOLD_MIN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ext_rst_req_n,
   input  logic       sw_rst_req,
   output logic       periph_rst,
   output logic       core_rst,
   output logic       seq_done,
   output logic [2:0] seq_state
);

   localparam int CNT_W = cnt_width(STARTUP_CYCLES, GAP_CYCLES, HOLD_MIN);

   localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_MIN - 1);
   localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

   logic             w_ext_sync;
   logic             w_req;
   state_e           r_state;
   state_e           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_periph_rst;
   logic             r_core_rst;
   logic             r_seq_done;
   logic             w_periph_rst_nxt;
   logic             w_core_rst_nxt;
   logic             w_seq_done_nxt;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_ext_sync (
      .clk (clk),
      .rst (rst),
      .i_d (ext_rst_req_n),
      .o_q (w_ext_sync)
   );

   // Button and software requests merge into a single request.
   assign w_req = (~w_ext_sync) | sw_rst_req;

   // Saturating counter increment so the count can never wrap.
   always_comb begin
      if (r_cnt == CNT_MAX) begin
         w_cnt_inc = r_cnt;
      end else begin
         w_cnt_inc = r_cnt + CNT_ONE;
      end
   end

   // Next-state and next-count logic; a request always wins.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_req) begin
         w_state_nxt = ST_HOLD;
         w_cnt_nxt   = CNT_ZERO;
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  w_state_nxt = ST_WAIT_STABLE;
                  w_cnt_nxt   = CNT_ZERO;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            ST_WAIT_STABLE: begin
               if (r_cnt == STARTUP_LAST) begin
                  w_state_nxt = ST_REL_PERIPH;
                  w_cnt_nxt   = CNT_ZERO;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            ST_REL_PERIPH: begin
               w_state_nxt = ST_WAIT_GAP;
               w_cnt_nxt   = CNT_ZERO;
            end
            ST_WAIT_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = CNT_ZERO;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            ST_RUN: begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = CNT_ZERO;
            end
            default: begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = CNT_ZERO;
            end
         endcase
      end
   end

   // Output decode, registered one cycle behind the state. The core reset is
   // released on the last WAIT_GAP cycle so the gap after the peripheral
   // release is exactly GAP_CYCLES; a request arriving on that same cycle
   // suppresses the release so the core never sees a partial release.
   always_comb begin
      w_periph_rst_nxt = 1'b1;
      w_core_rst_nxt   = 1'b1;
      case (r_state)
         ST_REL_PERIPH: begin
            w_periph_rst_nxt = 1'b0;
         end
         ST_WAIT_GAP: begin
            w_periph_rst_nxt = 1'b0;
            if ((r_cnt == GAP_LAST) && !w_req) begin
               w_core_rst_nxt = 1'b0;
            end else begin
               w_core_rst_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            w_periph_rst_nxt = 1'b0;
            w_core_rst_nxt   = 1'b0;
         end
         default: begin
            w_periph_rst_nxt = 1'b1;
            w_core_rst_nxt   = 1'b1;
         end
      endcase
      // seq_done tracks the state register exactly by following the next state.
      if (w_state_nxt == ST_RUN) begin
         w_seq_done_nxt = 1'b1;
      end else begin
         w_seq_done_nxt = 1'b0;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_HOLD;
         r_cnt        <= CNT_ZERO;
         r_periph_rst <= 1'b1;
         r_core_rst   <= 1'b1;
         r_seq_done   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_periph_rst <= w_periph_rst_nxt;
         r_core_rst   <= w_core_rst_nxt;
         r_seq_done   <= w_seq_done_nxt;
      end
   end

   assign periph_rst = r_periph_rst;
   assign core_rst   = r_core_rst;
   assign seq_done   = r_seq_done;
   assign seq_state  = r_state;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset.
  - clk: the 160 MHz RCOSC global clock.
  - rst: synchronous, active-high.
REQ-002 Parameters SHALL be (name, default, meaning):
  - STARTUP_CYCLES, 1024: stabilisation delay after reset/request before any release.
  - GAP_CYCLES, 16: cycles between peripheral release and core release.
  - HOLD_MIN, 8: minimum cycles resets stay asserted in HOLD.
REQ-003 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1: system clock.
  - rst, in, 1: synchronous active-high reset.
  - ext_rst_req_n, in, 1: asynchronous board reset button, active-low.
  - sw_rst_req, in, 1: single-cycle software reset request pulse, synchronous.
  - periph_rst, out, 1: active-high reset to bus/peripheral logic.
  - core_rst, out, 1: active-high reset to Kyber core.
  - seq_done, out, 1: high while state is RUN.
  - seq_state, out, 3: current state encoding, for debug.

Function
REQ-004 ext_rst_req_n SHALL pass through a 2-flop synchroniser; the request is active when the synchronised value is 0.
REQ-005 States SHALL be HOLD(0), WAIT_STABLE(1), REL_PERIPH(2), WAIT_GAP(3), RUN(4); encodings 5-7 SHALL go to HOLD on the next cycle.
REQ-006 HOLD SHALL behave as follows:
  - periph_rst=1 and core_rst=1.
  - Counter counts HOLD_MIN cycles.
  - Move to WAIT_STABLE only when the count is done and no request is active.
REQ-007 WAIT_STABLE SHALL keep both resets asserted and count STARTUP_CYCLES cycles, then move to REL_PERIPH.
REQ-008 REL_PERIPH SHALL last 1 cycle and deassert periph_rst from its first cycle, then move to WAIT_GAP.
REQ-009 WAIT_GAP SHALL keep core_rst=1 for GAP_CYCLES cycles, then move to RUN.
REQ-010 In RUN, core_rst=0, periph_rst=0 and seq_done=1.
REQ-011 An active request (synchronised ext or sw_rst_req) in any state other than HOLD SHALL go to HOLD on the next cycle, clear the counter, and assert both resets in that cycle.
  - In HOLD, a request SHALL restart the HOLD_MIN count.
REQ-012 Outputs SHALL be registered; a request sampled at edge N SHALL be visible on core_rst/periph_rst after edge N+1.
REQ-013 The counter SHALL be sized by $clog2 of the largest parameter plus 1 and SHALL NOT wrap.
  - Terminal-count comparisons are equality on count==PARAM-1.
REQ-014 Simultaneous ext and sw requests SHALL be treated as one request.
REQ-015 The state machine SHALL never release core_rst before periph_rst.

Reset
REQ-016 On rst=1, the block SHALL load the following values on the next edge:
  - state=HOLD, counter=0, synchroniser flops=1 (inactive).
  - periph_rst=1, core_rst=1, seq_done=0, seq_state=0.
REQ-017 rst asserted mid-sequence SHALL override all requests and counters with no partial release.

Structure
REQ-018 The following SHALL live in shared package rst_seq_pkg:
  - State enum.
  - Default parameter constants.
REQ-019 The synchroniser SHALL be the sub-module sync_2ff (1-bit, reset value parameter); all other logic stays in reset_sequencer.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
  - Nominal release: rst for 3 cycles, then idle inputs -> periph_rst falls at cycle HOLD_MIN+STARTUP_CYCLES+1 after rst release (1033); core_rst falls 16 cycles later; seq_done=1.
  - Software request in RUN: sw_rst_req 1-cycle pulse in RUN -> both resets=1 two edges later; full sequence repeats; seq_done=0 until recompletion.
  - Request during WAIT_GAP: ext_rst_req_n low for 1 cycle during WAIT_GAP -> state HOLD; core_rst never deasserted; periph_rst reasserted.
  - Held button: ext_rst_req_n held low for 100 cycles -> stays in HOLD for all 100+2 cycles; release starts a fresh HOLD_MIN count.
  - Reset mid-WAIT_STABLE: rst pulse at count 500 -> counter=0, state=HOLD; release time measured from rst deassertion.
  - Parameter override: STARTUP_CYCLES=4, GAP_CYCLES=1, HOLD_MIN=1 -> periph_rst falls 6 cycles after rst release; core_rst falls 1 cycle later; illegal state forced via bench goes to HOLD next cycle.
